// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Brief    : Shared constants, state encoding and helpers for the snake mover.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [5:0] X_MIN = 6'd1;
    localparam logic [5:0] X_MAX = 6'd38;
    localparam logic [4:0] Y_MIN = 5'd1;
    localparam logic [4:0] Y_MAX = 5'd28;

    localparam logic [5:0] START_X   = 6'd20;
    localparam logic [4:0] START_Y   = 5'd15;
    localparam logic [4:0] START_LEN = 5'd3;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    // Encoding pairs up/down and left/right on bit 0, so the reverse is an XOR.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : snake_tick_gen
// Brief    : Free-running move-step counter; tick is high in the last count.
// Revision : 1.0 - initial release
// ============================================================================
module snake_tick_gen #(
    parameter int TICK_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/snake_body_mover.sv
`default_nettype none
// ============================================================================
// Module   : snake_body_mover
// Brief    : Moves the snake per tick, tracks body, grows, detects collisions
//            and answers registered per-cell occupancy queries.
// Revision : 1.0 - initial release
// ============================================================================
module snake_body_mover
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES = 250000,
    parameter int MAX_LEN     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    input  logic       inc_len,
    input  logic [5:0] q_x,
    input  logic [4:0] q_y,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [4:0] length,
    output logic       move_tick,
    output logic       game_over,
    output logic       q_hit,
    output logic       q_is_head
);

    state_t     state_q,        state_d;
    logic [5:0] seg_x_q [MAX_LEN];
    logic [5:0] seg_x_d [MAX_LEN];
    logic [4:0] seg_y_q [MAX_LEN];
    logic [4:0] seg_y_d [MAX_LEN];
    logic [4:0] length_q,       length_d;
    logic [1:0] cur_dir_q,      cur_dir_d;
    logic [1:0] next_dir_q,     next_dir_d;
    logic       grow_pending_q, grow_pending_d;
    logic       inc_len_dly_q;
    logic       move_tick_q,    move_tick_d;
    logic       game_over_q,    game_over_d;
    logic       q_hit_q,        q_hit_d;
    logic       q_is_head_q,    q_is_head_d;

    logic       tick;
    logic       dir_ok;
    logic [1:0] dir_eff;
    logic       grow_req;
    logic       can_grow;
    logic [5:0] nh_x;
    logic [4:0] nh_y;
    logic       wall_hit;
    logic       body_hit;
    logic [4:0] body_len;

    snake_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Request visible in the move cycle itself still steers that move.
    always_comb begin
        dir_ok   = dir_valid && (dir_in != opposite_dir(cur_dir_q));
        dir_eff  = dir_ok ? dir_in : next_dir_q;
        grow_req = grow_pending_q | (inc_len & ~inc_len_dly_q);
        can_grow = grow_req && (length_q != 5'(MAX_LEN));
        body_len = can_grow ? length_q : (length_q - 5'd1);

        nh_x = seg_x_q[0];
        nh_y = seg_y_q[0];
        case (dir_eff)
            DIR_UP:    nh_y = seg_y_q[0] - 5'd1;
            DIR_DOWN:  nh_y = seg_y_q[0] + 5'd1;
            DIR_LEFT:  nh_x = seg_x_q[0] - 6'd1;
            default:   nh_x = seg_x_q[0] + 6'd1;
        endcase

        wall_hit = (nh_x < X_MIN) || (nh_x > X_MAX) || (nh_y < Y_MIN) || (nh_y > Y_MAX);

        // Tail cell is excluded unless the snake actually lengthens this move.
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) < body_len) && (seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y)) begin
                body_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        seg_x_d        = seg_x_q;
        seg_y_d        = seg_y_q;
        length_d       = length_q;
        cur_dir_d      = cur_dir_q;
        next_dir_d     = dir_eff;
        grow_pending_d = grow_req;
        move_tick_d    = 1'b0;
        game_over_d    = game_over_q;

        if ((state_q == ST_RUN) && tick) begin
            if (wall_hit || body_hit) begin
                state_d     = ST_OVER;
                game_over_d = 1'b1;
            end else begin
                for (int i = MAX_LEN - 1; i >= 1; i--) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0]     = nh_x;
                seg_y_d[0]     = nh_y;
                cur_dir_d      = dir_eff;
                grow_pending_d = 1'b0;
                move_tick_d    = 1'b1;
                if (can_grow) begin
                    length_d = length_q + 5'd1;
                end
            end
        end
    end

    always_comb begin
        q_hit_d = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < length_q) && (seg_x_q[i] == q_x) && (seg_y_q[i] == q_y)) begin
                q_hit_d = 1'b1;
            end
        end
        q_is_head_d = (seg_x_q[0] == q_x) && (seg_y_q[0] == q_y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            length_q       <= START_LEN;
            cur_dir_q      <= DIR_RIGHT;
            next_dir_q     <= DIR_RIGHT;
            grow_pending_q <= 1'b0;
            inc_len_dly_q  <= 1'b0;
            move_tick_q    <= 1'b0;
            game_over_q    <= 1'b0;
            q_hit_q        <= 1'b0;
            q_is_head_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < 3) ? (START_X - 6'(i)) : 6'd0;
                seg_y_q[i] <= (i < 3) ? START_Y : 5'd0;
            end
        end else begin
            state_q        <= state_d;
            seg_x_q        <= seg_x_d;
            seg_y_q        <= seg_y_d;
            length_q       <= length_d;
            cur_dir_q      <= cur_dir_d;
            next_dir_q     <= next_dir_d;
            grow_pending_q <= grow_pending_d;
            inc_len_dly_q  <= inc_len;
            move_tick_q    <= move_tick_d;
            game_over_q    <= game_over_d;
            q_hit_q        <= q_hit_d;
            q_is_head_q    <= q_is_head_d;
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = {1'b0, seg_y_q[0]};
    assign length    = length_q;
    assign move_tick = move_tick_q;
    assign game_over = game_over_q;
    assign q_hit     = q_hit_q;
    assign q_is_head = q_is_head_q;

endmodule
`default_nettype wire
